// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types for the instruction-fetch sequencer:
//   fetch_state_t : sequencer state encoding
//   redirect_t    : a PC redirect request (valid, exception flag, target)
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_REDIR = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_exc;
    logic [31:0] target;
  } redirect_t;

  localparam redirect_t REDIRECT_NONE = '{valid: 1'b0, is_exc: 1'b0, target: 32'h0};

endpackage

// File: rtl/fetch_redirect_buf.sv
// ---------------------------------------------------------------------------
// fetch_redirect_buf
// Holds the pending PC redirect and merges it with redirect pulses arriving
// this cycle. An exception always wins over a branch, whether the branch is
// pending or pulsing; a branch never displaces a pending exception.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_branch_valid/i_branch_target  one-cycle branch redirect pulse
//   i_exc_valid/i_exc_target        one-cycle exception redirect pulse
//   i_clear                         redirect consumed this cycle
//   o_redirect                      pending merged with this cycle's pulses
//   o_pending                       registered pending redirect
// ---------------------------------------------------------------------------
module fetch_redirect_buf
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_branch_valid,
  input  logic [31:0] i_branch_target,
  input  logic        i_exc_valid,
  input  logic [31:0] i_exc_target,
  input  logic        i_clear,
  output redirect_t   o_redirect,
  output redirect_t   o_pending
);

  redirect_t r_pending;
  redirect_t w_pulse;
  redirect_t w_merged;
  logic      w_pending_exc;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_pulse = REDIRECT_NONE;
    if (i_exc_valid) begin
      w_pulse = '{valid: 1'b1, is_exc: 1'b1, target: i_exc_target};
    end else if (i_branch_valid) begin
      w_pulse = '{valid: 1'b1, is_exc: 1'b0, target: i_branch_target};
    end
  end

  assign w_pending_exc = r_pending.valid && r_pending.is_exc;

  // A pulse replaces the pending entry unless it is a branch trying to
  // displace a pending exception.
  always_comb begin
    w_merged = r_pending;
    if (w_pulse.valid && !(w_pending_exc && !w_pulse.is_exc)) begin
      w_merged = w_pulse;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= REDIRECT_NONE;
    end else if (i_clear) begin
      // The consumed redirect is dropped; a fresh pulse in the same cycle
      // still becomes the next pending redirect.
      r_pending <= w_pulse;
    end else begin
      r_pending <= w_merged;
    end
  end

  assign o_redirect = w_merged;
  assign o_pending  = r_pending;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer between the PC and the instruction bus. Each
// cycle it holds, advances or redirects the PC, runs at most one bus
// transaction, kills wrong-path responses and hands instructions to decode
// with a valid/stall handshake.
//
// Build option: define FETCH_CTRL_PERF_EN to enable the performance
// counters; otherwise the perf_* ports are tied to zero.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   pc_address, pc_alignment_error     current PC and its misalignment flag
//   pc_stall                           hold PC when 1
//   pc_branch_taken/pc_branch_address  branch redirect to PC
//   pc_exc_taken/pc_exc_address        exception redirect to PC
//   branch_valid/branch_target         branch pulse from execute
//   exc_valid/exc_target               exception pulse from commit
//   inst_req/inst_addr                 bus request
//   inst_addr_ok/inst_data_ok/inst_rdata  bus response
//   if_valid/if_pc/if_inst/if_adel     output to decode
//   id_stall                           decode cannot accept
//   perf_fetch_cnt/perf_kill_cnt/perf_stall_cnt  performance counters
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_address,
  input  logic             pc_alignment_error,
  output logic             pc_stall,
  output logic             pc_branch_taken,
  output logic [31:0]      pc_branch_address,
  output logic             pc_exc_taken,
  output logic [31:0]      pc_exc_address,
  input  logic             branch_valid,
  input  logic [31:0]      branch_target,
  input  logic             exc_valid,
  input  logic [31:0]      exc_target,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             if_adel,
  input  logic             id_stall,
  output logic [CNT_W-1:0] perf_fetch_cnt,
  output logic [CNT_W-1:0] perf_kill_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  fetch_state_t r_state, w_state_next;
  logic         r_req_active, w_req_active_next;
  logic         r_kill, w_kill_next;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_hold_inst;

  redirect_t    w_redirect;
  redirect_t    w_pending;
  logic         w_clear;
  logic         w_kill;
  logic         w_pulse;

  logic         w_pc_stall, w_br_taken, w_exc_taken;
  logic [31:0]  w_br_addr, w_exc_addr;
  logic         w_inst_req;
  logic [31:0]  w_inst_addr;
  logic         w_if_valid, w_if_adel;
  logic [31:0]  w_if_pc, w_if_inst;

  fetch_redirect_buf u_redirect_buf (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_branch_valid  (branch_valid),
    .i_branch_target (branch_target),
    .i_exc_valid     (exc_valid),
    .i_exc_target    (exc_target),
    .i_clear         (w_clear),
    .o_redirect      (w_redirect),
    .o_pending       (w_pending)
  );

  assign w_pulse = branch_valid || exc_valid;
  // Any redirect seen while waiting makes the outstanding response wrong-path.
  assign w_kill  = r_kill || w_redirect.valid;

  always_comb begin
    w_state_next      = r_state;
    w_req_active_next = 1'b0;
    w_kill_next       = r_kill;
    w_clear           = 1'b0;
    w_pc_stall        = 1'b1;
    w_br_taken        = 1'b0;
    w_br_addr         = 32'h0;
    w_exc_taken       = 1'b0;
    w_exc_addr        = 32'h0;
    w_inst_req        = 1'b0;
    w_inst_addr       = 32'h0;
    w_if_valid        = 1'b0;
    w_if_pc           = 32'h0;
    w_if_inst         = 32'h0;
    w_if_adel         = 1'b0;

    unique case (r_state)
      S_REQ: begin
        // Once inst_req is up it must stay stable until inst_addr_ok, so a
        // redirect only short-circuits the entry cycle; later ones kill the
        // response in S_WAIT instead.
        if (w_redirect.valid && !r_req_active) begin
          w_state_next = S_REDIR;
        end else if (pc_alignment_error && !r_req_active) begin
          w_if_valid = 1'b1;
          w_if_adel  = 1'b1;
          w_if_pc    = pc_address;
          if (!id_stall) begin
            w_pc_stall = 1'b0;
          end
        end else begin
          w_inst_req        = 1'b1;
          w_inst_addr       = pc_address;
          w_req_active_next = !inst_addr_ok;
          if (inst_addr_ok) begin
            w_pc_stall   = 1'b0;
            w_state_next = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        w_kill_next = w_kill;
        if (inst_data_ok) begin
          if (w_kill) begin
            w_state_next = S_REDIR;
          end else begin
            w_if_valid   = 1'b1;
            w_if_pc      = r_fetch_pc;
            w_if_inst    = inst_rdata;
            w_state_next = id_stall ? S_HOLD : S_REQ;
          end
        end
      end

      S_HOLD: begin
        if (w_pulse) begin
          w_state_next = S_REDIR;
        end else begin
          w_if_valid = 1'b1;
          w_if_pc    = r_fetch_pc;
          w_if_inst  = r_hold_inst;
          if (!id_stall) begin
            w_state_next = S_REQ;
          end
        end
      end

      S_REDIR: begin
        w_pc_stall   = 1'b0;
        w_exc_taken  = w_pending.valid && w_pending.is_exc;
        w_br_taken   = w_pending.valid && !w_pending.is_exc;
        w_exc_addr   = w_exc_taken ? w_pending.target : 32'h0;
        w_br_addr    = w_br_taken  ? w_pending.target : 32'h0;
        w_clear      = 1'b1;
        w_kill_next  = 1'b0;
        w_state_next = S_REQ;
      end

      default: w_state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_req_active <= 1'b0;
      r_kill       <= 1'b0;
      r_fetch_pc   <= 32'h0;
      r_hold_inst  <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_req_active <= w_req_active_next;
      r_kill       <= w_kill_next;
      if (r_state == S_REQ && w_inst_req && inst_addr_ok) begin
        r_fetch_pc <= pc_address;
      end
      if (r_state == S_WAIT && inst_data_ok && !w_kill && id_stall) begin
        r_hold_inst <= inst_rdata;
      end
    end
  end

  // Outputs are forced to their reset values while rst_n is low, so a reset
  // abandons an in-flight transaction within the same cycle.
  assign pc_stall          = rst_n ? w_pc_stall  : 1'b1;
  assign pc_branch_taken   = rst_n && w_br_taken;
  assign pc_branch_address = rst_n ? w_br_addr   : 32'h0;
  assign pc_exc_taken      = rst_n && w_exc_taken;
  assign pc_exc_address    = rst_n ? w_exc_addr  : 32'h0;
  assign inst_req          = rst_n && w_inst_req;
  assign inst_addr         = rst_n ? w_inst_addr : 32'h0;
  assign if_valid          = rst_n && w_if_valid;
  assign if_pc             = rst_n ? w_if_pc     : 32'h0;
  assign if_inst           = rst_n ? w_if_inst   : 32'h0;
  assign if_adel           = rst_n && w_if_adel;

`ifdef FETCH_CTRL_PERF_EN
  logic             w_accept, w_discard;
  logic [CNT_W-1:0] r_fetch_cnt, r_kill_cnt, r_stall_cnt;

  assign w_accept  = w_if_valid && !id_stall;
  assign w_discard = (r_state == S_WAIT && inst_data_ok && w_kill) ||
                     (r_state == S_HOLD && w_pulse);

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_kill_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept)               r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (w_discard)              r_kill_cnt  <= r_kill_cnt + 1'b1;
      if (w_if_valid && id_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_kill_cnt  = r_kill_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_kill_cnt  = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
